// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the icache refill
// path and the dcache refill/writeback path; one transaction in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;     // 1 = last grant went to the dcache
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0]   dc_rdata_q, dc_rdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        unique case (state_q)
            IDLE: begin
                // On contention the side that did not win last time gets the port.
                if (dc_req && (!ic_req || !last_d_q)) begin
                    state_d  = BUSY_D;
                    addr_d   = dc_addr;
                    we_d     = dc_we;
                    wdata_d  = dc_wdata;
                    last_d_d = 1'b1;
                end else if (ic_req) begin
                    state_d  = BUSY_I;
                    addr_d   = ic_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    last_d_d = 1'b0;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    ic_rdata_d = mem_rdata;
                    state_d    = DONE_I;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        dc_rdata_d = mem_rdata;
                    end
                    state_d = DONE_D;
                end
            end
            DONE_I:  state_d = IDLE;
            DONE_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoded from the state register so an async reset drops them immediately.
    assign mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign ic_done   = (state_q == DONE_I);
    assign dc_done   = (state_q == DONE_D);
    assign busy      = (state_q != IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters and memory model drive the DUT,
// a monitor pops per-side expected transactions whenever a done pulse appears.
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0]  addr;
        logic         we;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } txn_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req, ic_done, dc_req, dc_we, dc_done;
    logic [31:0]  ic_addr, dc_addr, mem_addr;
    logic [127:0] ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;
    logic         mem_req, mem_we, mem_ready, busy;

    mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    txn_t ic_issue_q[$], dc_issue_q[$], ic_exp_q[$], dc_exp_q[$];
    int   grant_log[$];                  // 0 = I, 1 = D, in completion order
    int   ic_done_cnt = 0, dc_done_cnt = 0;
    int   ic_req_cyc = 0, dc_req_cyc = 0, ic_lat = 0, dc_lat = 0;
    logic [127:0] dc_shadow;

    logic [31:0]  cap_addr;
    logic         cap_we;
    logic [127:0] cap_wdata;
    int           mem_lat = 0;
    bit           mem_tie = 1'b0;
    int           mem_cnt = 0;

    function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        if (a == 32'h100) return 128'hDEADBEEF_00000001_00000002_00000003;
        return {a, ~a, a ^ 32'h5A5A5A5A, 32'h0000_0001};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: ready after mem_lat+1 BUSY cycles, or permanently when tied.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            bit rdy;
            @(negedge clk);
            if (mem_req) begin
                if (mem_cnt == 0) begin
                    cap_addr  = mem_addr;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                end else begin
                    check("hold_addr", mem_addr, cap_addr);
                    check("hold_we", mem_we, cap_we);
                    check("hold_wdata", mem_wdata, cap_wdata);
                end
                mem_cnt++;
                rdy = mem_tie || (mem_cnt > mem_lat);
            end else begin
                mem_cnt = 0;
                rdy = mem_tie;
            end
            mem_ready = rdy;
            mem_rdata = rdy ? mem_line(mem_addr) : {4{32'hBAADF00D}};
        end
    end

    initial begin
        txn_t t;
        ic_req = 1'b0; ic_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset || ic_done) begin
                ic_req = 1'b0;
            end else if (!ic_req && ic_issue_q.size() > 0) begin
                t = ic_issue_q.pop_front();
                ic_addr = t.addr; ic_req = 1'b1; ic_req_cyc = cyc;
            end
        end
    end

    initial begin
        txn_t t;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
        forever begin
            @(negedge clk);
            if (!reset || dc_done) begin
                dc_req = 1'b0;
            end else if (!dc_req && dc_issue_q.size() > 0) begin
                t = dc_issue_q.pop_front();
                dc_addr = t.addr; dc_we = t.we; dc_wdata = t.wdata;
                dc_req = 1'b1; dc_req_cyc = cyc;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        txn_t e;
        logic prev_ic = 1'b0, prev_dc = 1'b0;
        forever begin
            @(negedge clk);
            if (ic_done || dc_done) begin
                check("single_done", ic_done & dc_done, 0);
                check("busy_in_done", busy, 1);
                check("memreq_in_done", mem_req, 0);
                check("done_pulse", (ic_done & prev_ic) | (dc_done & prev_dc), 0);
            end
            if (ic_done) begin
                ic_done_cnt++; grant_log.push_back(0); ic_lat = cyc - ic_req_cyc;
                if (ic_exp_q.size() == 0) begin
                    check("ic_unexpected_done", ic_done, 0);
                end else begin
                    e = ic_exp_q.pop_front();
                    check("ic_mem_addr", cap_addr, e.addr);
                    check("ic_mem_we", cap_we, 0);
                    check("ic_mem_wdata", cap_wdata, 0);
                    check("ic_rdata", ic_rdata, e.rdata);
                    $display("txn I addr=%h rdata=%h lat=%0d", e.addr, ic_rdata, ic_lat);
                end
            end
            if (dc_done) begin
                dc_done_cnt++; grant_log.push_back(1); dc_lat = cyc - dc_req_cyc;
                if (dc_exp_q.size() == 0) begin
                    check("dc_unexpected_done", dc_done, 0);
                end else begin
                    e = dc_exp_q.pop_front();
                    check("dc_mem_addr", cap_addr, e.addr);
                    check("dc_mem_we", cap_we, e.we);
                    check("dc_mem_wdata", cap_wdata, e.wdata);
                    check("dc_rdata", dc_rdata, e.rdata);
                    $display("txn D addr=%h we=%0b rdata=%h lat=%0d", e.addr, e.we, dc_rdata, dc_lat);
                end
            end
            prev_ic = ic_done;
            prev_dc = dc_done;
        end
    end

    task automatic push_ic(input logic [31:0] a);
        txn_t t;
        t.addr = a; t.we = 1'b0; t.wdata = '0; t.rdata = mem_line(a);
        ic_exp_q.push_back(t);
        ic_issue_q.push_back(t);
    endtask

    task automatic push_dc(input logic [31:0] a, input logic w, input logic [127:0] wd);
        txn_t t;
        t.addr = a; t.we = w; t.wdata = wd;
        t.rdata = w ? dc_shadow : mem_line(a);
        if (!w) dc_shadow = mem_line(a);
        dc_exp_q.push_back(t);
        dc_issue_q.push_back(t);
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((ic_issue_q.size() > 0 || dc_issue_q.size() > 0 || ic_req || dc_req || busy)
               && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("quiet_timeout", n >= budget, 0);
        check("exp_drained", ic_exp_q.size() + dc_exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dones"}, {ic_done, dc_done}, 0);
        check({tag, "_mem_bus"}, {mem_we, mem_addr, mem_wdata}, 0);
        check({tag, "_rdata"}, ic_rdata | dc_rdata, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        dc_shadow = '0;
        grant_log.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc_before;
        int n;
        reset = 1'b1;
        #1 reset = 1'b0;
        dc_shadow = '0;
        do_reset();

        // Single icache refill, memory ready 3 cycles after mem_req
        mem_lat = 3;
        push_ic(32'h100);
        wait_quiet(50);
        check("ic_latency", ic_lat, 5);
        check("ic_rdata_line", ic_rdata, 128'hDEADBEEF_00000001_00000002_00000003);
        check("dc_idle_count", dc_done_cnt, 0);

        // Dcache refill then writeback; writeback leaves dc_rdata alone
        push_dc(32'h3000, 1'b0, '0);
        push_dc(32'h2000, 1'b1, {16{8'hA5}});
        wait_quiet(50);
        check("dc_rdata_kept", dc_rdata, mem_line(32'h3000));
        check("dc_done_count", dc_done_cnt, 2);

        // Simultaneous pairs: D first after reset, alternating afterwards
        do_reset();
        mem_lat = 1;
        push_ic(32'h400); push_dc(32'h500, 1'b0, '0);
        wait_quiet(50);
        push_dc(32'h540, 1'b0, '0);
        wait_quiet(50);
        push_ic(32'h440); push_dc(32'h580, 1'b0, '0);
        wait_quiet(50);
        check("pair_len", grant_log.size(), 5);
        check("pair_order", {grant_log[0][0], grant_log[1][0], grant_log[2][0],
                             grant_log[3][0], grant_log[4][0]}, 5'b10101);

        // Starvation: both sides keep requesting for 10 transactions
        do_reset();
        dc_before = ic_done_cnt;
        for (int i = 0; i < 5; i++) begin
            push_ic(32'h1000 + 32'(i * 16));
            push_dc(32'h8000 + 32'(i * 16), 1'(i % 2), {4{32'(i)}});
        end
        wait_quiet(200);
        check("starve_len", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            check($sformatf("starve_grant%0d", i), grant_log[i], (i % 2 == 0) ? 1 : 0);
        check("starve_ic_count", ic_done_cnt - dc_before, 5);

        // mem_ready tied high: ignored in IDLE, minimum latency otherwise
        mem_tie = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready_busy", busy, 0);
            check("idle_ready_req", mem_req, 0);
        end
        push_dc(32'h600, 1'b0, '0);
        wait_quiet(50);
        check("min_latency", dc_lat, 2);
        mem_tie = 1'b0;

        // Async reset in the middle of a BUSY_D transaction
        mem_lat = 6;
        dc_before = dc_done_cnt;
        begin
            txn_t t;
            t.addr = 32'h700; t.we = 1'b0; t.wdata = '0; t.rdata = '0;
            dc_issue_q.push_back(t);
        end
        n = 0;
        while (!mem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_start_timeout", n >= 20, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        dc_shadow = '0;
        repeat (2) @(negedge clk);
        check("abort_no_done", dc_done_cnt, dc_before);
        mem_lat = 2;
        push_ic(32'h800);
        wait_quiet(50);
        check("post_abort_lat", ic_lat, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
